rot_step_tracker: RTL and testbench

ROT_STEP_TRACKER -- requirements
Module: rot_step_tracker

---
 rtl/rot_pkg.sv | 15 +
 rtl/rot_led_decode.sv | 19 +
 rtl/rot_step_tracker.sv | 139 +++++++++++++
 tb/tb_rot_step_tracker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared definitions for the rotary step tracker: FSM encoding, direction
// and drop-counter constants. Used by rot_step_tracker and its LED decoder.
package rot_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StStep = 2'd1,
    StLock = 2'd2
  } state_e;

  localparam logic       DIR_INC  = 1'b1;
  localparam logic       DIR_DEC  = 1'b0;
  localparam logic [7:0] DROP_MAX = 8'd255;

endpackage

// File: rtl/rot_led_decode.sv
// One-hot LED bar decoder: turns the low position bits into a single lit LED.
// Purely combinational; exactly one output bit is always set.
module rot_led_decode #(
  parameter int unsigned LED_W = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [LED_W-1:0] led_o
);

  // Light the LED whose index matches the position bits.
  always_comb begin
    led_o = '0;
    for (int i = 0; i < LED_W; i++) begin
      led_o[i] = (idx_i == IDX_W'(i));
    end
  end

endmodule

// File: rtl/rot_step_tracker.sv
// Rotary detent tracker: edge-detects the upstream step level, accepts one
// step per lockout window, keeps a position counter and counts dropped steps.
// Build option: define ROT_WRAP_EN to make position wrap modulo 2^POS_W;
// otherwise it saturates at 0 and at max.
module rot_step_tracker
  import rot_pkg::*;
#(
  parameter int unsigned POS_W   = 8,
  parameter int unsigned LED_W   = 8,
  parameter int unsigned LOCKOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rotation_event,
  input  logic             rotation_direction,
  output logic [POS_W-1:0] position,
  output logic [LED_W-1:0] led,
  output logic             step_pulse,
  output logic             step_dir,
  output logic             at_limit,
  output logic [7:0]       dropped_cnt
);

  localparam int unsigned CNT_W     = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam int unsigned LOCK_LOAD = (LOCKOUT > 0) ? LOCKOUT - 1 : 0;
  localparam int unsigned IDX_W     = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam logic [POS_W-1:0] PosMax = '1;

  state_e           state_q, state_d;
  logic             event_q;
  logic             arm_q, arm_d;
  logic             dir_q, dir_d;
  logic             step_dir_q, step_dir_d;
  logic             pulse_q, pulse_d;
  logic [POS_W-1:0] position_q, position_d, pos_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             rise;

  // arm_q blocks an event that was already high when reset released: it must
  // be seen low once before any rising edge counts.
  assign rise = rotation_event & ~event_q & arm_q;

  // Position after one step in direction dir_q.
  always_comb begin
`ifdef ROT_WRAP_EN
    pos_step = (dir_q == DIR_INC) ? position_q + POS_W'(1) : position_q - POS_W'(1);
`else
    if (dir_q == DIR_INC) begin
      pos_step = (position_q == PosMax) ? position_q : position_q + POS_W'(1);
    end else begin
      pos_step = (position_q == '0) ? position_q : position_q - POS_W'(1);
    end
`endif
  end

  // Next-state logic for the step FSM, lockout counter and drop counter.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    position_d = position_q;
    cnt_d      = cnt_q;
    pulse_d    = 1'b0;
    step_dir_d = step_dir_q;
    drop_d     = drop_q;
    arm_d      = arm_q | ~rotation_event;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          dir_d   = rotation_direction;
          state_d = StStep;
        end
      end
      StStep: begin
        position_d = pos_step;
        pulse_d    = 1'b1;
        step_dir_d = dir_q;
        cnt_d      = CNT_W'(LOCK_LOAD);
        state_d    = (LOCKOUT == 0) ? StIdle : StLock;
      end
      StLock: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (rise && (state_q != StIdle) && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // State registers; asynchronous reset discards any pending step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      event_q    <= 1'b0;
      arm_q      <= 1'b0;
      dir_q      <= DIR_DEC;
      step_dir_q <= DIR_DEC;
      pulse_q    <= 1'b0;
      position_q <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      event_q    <= rotation_event;
      arm_q      <= arm_d;
      dir_q      <= dir_d;
      step_dir_q <= step_dir_d;
      pulse_q    <= pulse_d;
      position_q <= position_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
    end
  end

  logic [IDX_W-1:0] led_idx;
  assign led_idx = (LED_W > 1) ? position_q[IDX_W-1:0] : '0;

  rot_led_decode #(
    .LED_W (LED_W),
    .IDX_W (IDX_W)
  ) u_led_decode (
    .idx_i (led_idx),
    .led_o (led)
  );

  assign position    = position_q;
  assign step_pulse  = pulse_q;
  assign step_dir    = step_dir_q;
  assign dropped_cnt = drop_q;
  assign at_limit    = (position_q == '0) || (position_q == PosMax);

endmodule

// File: tb/tb_rot_step_tracker.sv
// Self-checking bench for rot_step_tracker (default parameters). Stimulus
// pushes the expected step outcome into a queue; a monitor pops and compares
// whenever step_pulse is seen.
module tb_rot_step_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       rotation_event;
  logic       rotation_direction;
  logic [7:0] position;
  logic [7:0] led;
  logic       step_pulse;
  logic       step_dir;
  logic       at_limit;
  logic [7:0] dropped_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic [7:0] pos;
    logic       dir;
    logic [7:0] led;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  rot_step_tracker dut (
    .clk                (clk),
    .rst                (rst),
    .rotation_event     (rotation_event),
    .rotation_direction (rotation_direction),
    .position           (position),
    .led                (led),
    .step_pulse         (step_pulse),
    .step_dir           (step_dir),
    .at_limit           (at_limit),
    .dropped_cnt        (dropped_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic push_exp(input logic [7:0] pos, input logic dir, input logic [7:0] l);
    exp_t e;
    e.pos = pos;
    e.dir = dir;
    e.led = l;
    exp_q.push_back(e);
  endtask

  // One-cycle high pulse on the event line; the rise is seen one edge later.
  task automatic detent(input logic d);
    @(posedge clk); #1;
    rotation_event     = 1'b1;
    rotation_direction = d;
    @(posedge clk); #1;
    rotation_event = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst                = 1'b1;
    rotation_event     = 1'b0;
    rotation_direction = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor.
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (step_pulse) begin
        check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got step_pulse=1 pos=0x%0h, required no pulse",
                   position);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_position", position, e.pos);
          check("sb_step_dir", step_dir, e.dir);
          check("sb_led", led, e.led);
        end
      end
      prev_pulse = step_pulse;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    rotation_event     = 1'b0;
    rotation_direction = 1'b0;
    idle(3);
    @(negedge clk);
    check("rst_position", position, 8'd0);
    check("rst_led", led, 8'h01);
    check("rst_at_limit", at_limit, 1'b1);
    check("rst_step_pulse", step_pulse, 1'b0);
    check("rst_step_dir", step_dir, 1'b0);
    check("rst_dropped", dropped_cnt, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Quiet after reset.
    idle(5);
    @(negedge clk);
    check("quiet_position", position, 8'd0);
    check("quiet_led", led, 8'h01);
    check("quiet_at_limit", at_limit, 1'b1);

    // Decrement from zero.
`ifdef ROT_WRAP_EN
    push_exp(8'd255, 1'b0, 8'h80);
`else
    push_exp(8'd0, 1'b0, 8'h01);
`endif
    detent(1'b0);
    idle(10);
    @(negedge clk);
    check("dec0_at_limit", at_limit, 1'b1);
    do_reset();

    // Three clean increments, 40 cycles apart.
    for (int k = 1; k <= 3; k++) begin
      push_exp(8'(k), 1'b1, 8'(1 << k));
      detent(1'b1);
      idle(38);
    end
    @(negedge clk);
    check("inc3_position", position, 8'd3);
    check("inc3_led", led, 8'h08);
    check("inc3_step_dir", step_dir, 1'b1);
    check("inc3_at_limit", at_limit, 1'b0);
    do_reset();
    @(negedge clk);
    check("rerst_position", position, 8'd0);
    check("rerst_step_dir", step_dir, 1'b0);
    check("rerst_led", led, 8'h01);

    // Second rise inside the lockout window is dropped.
    push_exp(8'd1, 1'b1, 8'h02);
    detent(1'b1);
    idle(4);
    detent(1'b1);
    idle(30);
    @(negedge clk);
    check("lock_position", position, 8'd1);
    check("lock_dropped", dropped_cnt, 8'd1);
    do_reset();

    // Reset right after a rise, released while the event is still high.
    @(posedge clk); #1;
    rotation_event     = 1'b1;
    rotation_direction = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2); #1;
    rst = 1'b0;
    idle(10);
    @(negedge clk);
    check("rstmid_position", position, 8'd0);
    @(posedge clk); #1;
    rotation_event = 1'b0;
    idle(2);
    push_exp(8'd1, 1'b1, 8'h02);
    detent(1'b1);
    idle(30);
    @(negedge clk);
    check("rstmid_after_position", position, 8'd1);
    do_reset();

    // Seven drops per lockout window until the drop counter saturates.
    for (int r = 1; r <= 43; r++) begin
      push_exp(8'(r), 1'b1, 8'(1 << (r % 8)));
      detent(1'b1);
      repeat (7) detent(1'b1);
      idle(10);
      if (r == 36) begin
        @(negedge clk);
        check("drop_252", dropped_cnt, 8'd252);
      end
    end
    @(negedge clk);
    check("drop_saturated", dropped_cnt, 8'd255);
    check("drop_position", position, 8'd43);

    idle(5);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
